run_control: RTL
================

// Module: run_control
// PURPOSE
// Run/halt/step/reset sequencer directly upstream of the phase-clock generator: produces its
// halt and reset inputs from front-panel buttons and the CPU's HLT signal. Halting always
// lands on an instruction-cycle boundary, after the internal phase completes, so the generator
// freezes with its next phase = cycle phase. Also stretches power-on and button resets.
// PARAMETERS
// DEBOUNCE_CYCLES  50000  clk cycles a synchronized button level must be stable to be accepted
// RESET_CYCLES     16     clk cycles the reset output is held after any reset cause ends
// START_RUNNING    0      1: leave RESET into RUN; 0: leave RESET into HALTED
// PORTS
// clk          in   1  system clock; all logic posedge
// reset_n      in   1  asynchronous, active-low reset
// btn_run      in   1  raw run/stop button (async, bouncy), active-high
// btn_step     in   1  raw single-step button (async, bouncy), active-high
// btn_reset    in   1  raw system-reset button (async, bouncy), active-high
// hlt_instr    in   1  CPU executed HLT; 1-clk pulse, synchronous to clk
// phase_last   in   1  internal_clock from the phase generator; high in final phase of a cycle
// halt         out  1  to generator: 1 = freeze phases
// reset        out  1  to generator and CPU: active-high synchronous reset
// running      out  1  1 while state == RUN
// state        out  2  debug: 00 RESET, 01 HALTED, 10 RUN, 11 STEP
// BEHAVIOUR
// - reset_n low (async): state=RESET, reset=1, halt=1, running=0, counters clear, debounced
//   levels=0, synchronizers=0, hlt_pending=0.
// - Buttons: 2-flop synchronizer each; debounced level takes the synced value on the edge where
//   the synced value has differed from it for DEBOUNCE_CYCLES consecutive clks (any mismatch
//   gap restarts the count). Press event = 1-clk pulse on debounced rising edge. Releases never
//   generate events. Raw edge -> press pulse = 2 + DEBOUNCE_CYCLES clks.
// - Outputs are registered from state: reset=1 only in RESET; halt=1 in RESET and HALTED;
//   halt=0 in RUN and STEP.
// - RESET: counter loads RESET_CYCLES-1 on entry, decrements each clk; on the edge it reads 0,
//   go RUN if START_RUNNING else HALTED.
// - HALTED: run press -> RUN; else step press -> STEP; hlt_instr ignored.
// - RUN: run press or hlt_instr sets hlt_pending. On edge with (hlt_pending | run press |
//   hlt_instr) & phase_last -> HALTED, hlt_pending clears. Step presses ignored.
// - STEP: on edge with phase_last=1 -> HALTED; exactly one full cycle executes (3 clks with
//   the 3-phase generator). Run/step presses and hlt_instr in STEP ignored.
// - btn_reset press: highest priority from any state -> RESET, counter reloads, hlt_pending
//   clears. Press while already in RESET restarts the count.
// - Simultaneous run+step presses in HALTED: run wins. hlt_instr + phase_last same edge in RUN:
//   halt that edge.
// - phase_last never sampled outside RUN/STEP; no counter wraps (reload only on entry).
// TESTING (bench: DEBOUNCE_CYCLES=4, RESET_CYCLES=8, START_RUNNING=0, model generator attached)
// - reset_n low 3 clks then high -> reset=1 for exactly 8 clks after release, then state=01,
//   halt=1, reset=0.
// - HALTED, btn_run high 10 clks -> press at clk 6 after raw edge, state=10 next edge, halt=0;
//   generator emits cycle,ram,internal repeating.
// - RUN, hlt_instr pulse while cycle phase high -> halt rises on the edge with internal phase
//   high; generator outputs all 0 after, next resume starts at cycle phase.
// - HALTED, step press -> state=11, exactly one cycle/ram/internal triple, back to 01; a second
//   step press during STEP produces no extra cycle.
// - btn_run toggling every 2 clks for 40 clks (bounce) -> no press event, state unchanged.
// - RUN, btn_reset press mid-cycle (ram phase) -> state=00 next edge, reset=1 for 8 clks,
//   hlt_pending cleared, ends in HALTED.

Source files
------------

// File: rtl/run_control.sv
// run_control: run/halt/step/reset sequencer feeding the phase-clock generator.
//
// Turns front-panel buttons and the CPU's HLT pulse into the generator's halt and
// reset controls. A halt request only takes effect on the final (internal) phase of
// an instruction cycle, so the generator always freezes with cycle phase next.
// Power-on and button resets are stretched to RESET_CYCLES clocks.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset_n     asynchronous active-low reset
//   btn_run     raw run/stop button (async, bouncy), active-high
//   btn_step    raw single-step button (async, bouncy), active-high
//   btn_reset   raw system-reset button (async, bouncy), active-high
//   hlt_instr   1-clk pulse: CPU executed HLT
//   phase_last  generator's internal phase (last phase of a cycle)
//   halt        1 = generator freezes its phases
//   reset       active-high synchronous reset to generator and CPU
//   running     1 while in RUN
//   state       debug: 00 RESET, 01 HALTED, 10 RUN, 11 STEP
module run_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned RESET_CYCLES    = 16,
  parameter bit          START_RUNNING   = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_run,
  input  logic       btn_step,
  input  logic       btn_reset,
  input  logic       hlt_instr,
  input  logic       phase_last,
  output logic       halt,
  output logic       reset,
  output logic       running,
  output logic [1:0] state
);

  localparam logic [1:0] StReset  = 2'b00;
  localparam logic [1:0] StHalted = 2'b01;
  localparam logic [1:0] StRun    = 2'b10;
  localparam logic [1:0] StStep   = 2'b11;

  localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RstW-1:0] RstLoad = RstW'(RESET_CYCLES - 1);

  // Button vector bit positions
  localparam int BtnRun   = 0;
  localparam int BtnStep  = 1;
  localparam int BtnReset = 2;

  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     level_q, level_d;
  logic [2:0]     press_q, press_d;
  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];

  logic [1:0]      state_q, state_d;
  logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
  logic            hlt_pending_q, hlt_pending_d;

  assign btn_raw = {btn_reset, btn_step, btn_run};
  assign state   = state_q;

  // Debounce: the count runs only while the synced value disagrees with the accepted
  // level; any agreeing clock clears it. A press is the registered rising acceptance.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      level_d[i]  = level_q[i];
      press_d[i]  = 1'b0;
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    hlt_pending_d = hlt_pending_q;
    if (press_q[BtnReset]) begin
      // Reset button wins from every state and restarts the stretch if already resetting
      state_d       = StReset;
      rst_cnt_d     = RstLoad;
      hlt_pending_d = 1'b0;
    end else begin
      case (state_q)
        StReset: begin
          if (rst_cnt_q == '0) begin
            state_d = START_RUNNING ? StRun : StHalted;
          end else begin
            rst_cnt_d = rst_cnt_q - 1'b1;
          end
        end
        StHalted: begin
          if (press_q[BtnRun]) begin
            state_d = StRun;
          end else if (press_q[BtnStep]) begin
            state_d = StStep;
          end
        end
        StRun: begin
          // Stop requests wait for the last phase so the cycle always completes
          if ((hlt_pending_q || press_q[BtnRun] || hlt_instr) && phase_last) begin
            state_d       = StHalted;
            hlt_pending_d = 1'b0;
          end else if (press_q[BtnRun] || hlt_instr) begin
            hlt_pending_d = 1'b1;
          end
        end
        StStep: begin
          if (phase_last) begin
            state_d = StHalted;
          end
        end
        default: state_d = StReset;
      endcase
    end
  end

  // Outputs come from flops loaded with the next state, so they track state_q exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StReset;
      rst_cnt_q     <= RstLoad;
      hlt_pending_q <= 1'b0;
      reset         <= 1'b1;
      halt          <= 1'b1;
      running       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      hlt_pending_q <= hlt_pending_d;
      reset         <= (state_d == StReset);
      halt          <= (state_d == StReset) || (state_d == StHalted);
      running       <= (state_d == StRun);
    end
  end

endmodule
